regfile_scoreboard: RTL and testbench

//  Next-generation CPU register file: NUM_READ_PORTS async read ports, NUM_WRITE_PORTS

---
 rtl/cpu_pkg.sv | 16 +
 rtl/regfile_bypass_mux.sv | 50 +++++
 rtl/regfile_scoreboard.sv | 123 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default register-file geometry and the register-file
// sequencer states, used by decode, issue, writeback and the register file.
// Latency: n/a (types and constants only). Backpressure: n/a.
package cpu_pkg;

  localparam int CPU_DATA_WIDTH     = 32;
  localparam int CPU_REG_ADDR_WIDTH = 5;

  // Register-file sequencer: CLEAR zeroes one entry per cycle after reset,
  // READY accepts reads, writes and reserves until the next reset.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port bypass: forwards same-cycle write data over the stored value
// and masks the pending bit when a write to the read address is in flight.
// Latency: combinational. Backpressure: none (no handshake, pure select).
// Ports:
//   read_addr       register being read
//   stored_dat      current array contents at read_addr
//   pending         scoreboard bit for read_addr
//   wr_en/addr/dat  all write ports, packed, port w at [w*width +: width]
//   read_dat        bypassed read data (0 for register 0)
//   read_busy       pending and not being written this cycle
module regfile_bypass_mux #(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int NUM_WRITE_PORTS = 2
) (
  input  logic [REG_ADDR_WIDTH-1:0]                 read_addr,
  input  logic [DATA_WIDTH-1:0]                     stored_dat,
  input  logic                                      pending,
  input  logic [NUM_WRITE_PORTS-1:0]                wr_en,
  input  logic [NUM_WRITE_PORTS*REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0]     wr_dat,
  output logic [DATA_WIDTH-1:0]                     read_dat,
  output logic                                      read_busy
);

  logic addr_nz;
  logic hit;

  assign addr_nz = (read_addr != '0);

  // Ascending scan so the highest-index matching port overrides lower ones,
  // mirroring the write priority in the array update.
  always_comb begin
    hit      = 1'b0;
    read_dat = stored_dat;
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      if (wr_en[w] && (wr_addr[w*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == read_addr)) begin
        hit      = 1'b1;
        read_dat = wr_dat[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (!addr_nz) begin
      hit      = 1'b0;
      read_dat = '0;
    end
  end

  assign read_busy = addr_nz && pending && !hit;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port CPU register file with write-to-read bypass, per-register pending
// bits for issue, and a post-reset sequencer that zeroes one entry per cycle.
// Latency: reads combinational, writes/reserves take effect on the next edge;
// backpressure: o_Ready low for 2**REG_ADDR_WIDTH edges after reset, inputs ignored then.
// Ports:
//   i_Clk, i_Reset                 clock, async active-high reset
//   i_Read_Addr / o_Read_Data      packed read ports, o_Read_Busy per port
//   i_Write_Enable/Addr/Data       packed write ports from writeback
//   i_Reserve_En / i_Reserve_Addr  mark a destination pending at issue
//   o_Ready                        clear sequence finished
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH      = CPU_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH  = CPU_REG_ADDR_WIDTH,
  parameter int NUM_READ_PORTS  = 2,
  parameter int NUM_WRITE_PORTS = 2
) (
  input  logic                                      i_Clk,
  input  logic                                      i_Reset,
  input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0]  i_Read_Addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]      o_Read_Data,
  output logic [NUM_READ_PORTS-1:0]                 o_Read_Busy,
  input  logic [NUM_WRITE_PORTS-1:0]                i_Write_Enable,
  input  logic [NUM_WRITE_PORTS*REG_ADDR_WIDTH-1:0] i_Write_Addr,
  input  logic [NUM_WRITE_PORTS*DATA_WIDTH-1:0]     i_Write_Data,
  input  logic                                      i_Reserve_En,
  input  logic [REG_ADDR_WIDTH-1:0]                 i_Reserve_Addr,
  output logic                                      o_Ready
);

  localparam int DW    = DATA_WIDTH;
  localparam int RAW   = REG_ADDR_WIDTH;
  localparam int DEPTH = 2**RAW;
  // Counter is one bit wider than an address so the end value DEPTH is
  // representable and the terminal compare needs no wrap handling.
  localparam logic [RAW:0] CNT_END = (RAW+1)'(DEPTH);

  rf_state_e            state_q, state_d;
  logic [RAW:0]         clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]     pend_q, pend_d;
  logic [DW-1:0]        regs_q [DEPTH];
  logic [DW-1:0]        regs_d [DEPTH];
  logic                 ready;
  logic [NUM_WRITE_PORTS-1:0] we_eff;

  assign ready   = (state_q == ST_READY);
  assign o_Ready = ready;
  // Writeback is ignored until the clear sequence finishes; gating here keeps
  // both the array update and the bypass path quiet during CLEAR.
  assign we_eff  = i_Write_Enable & {NUM_WRITE_PORTS{ready}};

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    pend_d    = pend_q;
    regs_d    = regs_q;
    if (state_q == ST_CLEAR) begin
      regs_d[clr_cnt_q[RAW-1:0]] = '0;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_d == CNT_END) begin
        state_d = ST_READY;
      end
    end else begin
      // Ascending loop: the highest-index port to the same address lands last.
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (we_eff[w] && (i_Write_Addr[w*RAW +: RAW] != '0)) begin
          regs_d[i_Write_Addr[w*RAW +: RAW]] = i_Write_Data[w*DW +: DW];
          pend_d[i_Write_Addr[w*RAW +: RAW]] = 1'b0;
        end
      end
      // Reserve after writes: a same-cycle reserve belongs to a newer producer.
      if (i_Reserve_En && (i_Reserve_Addr != '0)) begin
        pend_d[i_Reserve_Addr] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      pend_q    <= pend_d;
    end
  end

  // Contents are not reset; the CLEAR sequence zeroes them instead.
  always_ff @(posedge i_Clk) begin
    regs_q <= regs_d;
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [RAW-1:0] raddr;
    logic [DW-1:0]  mux_dat;
    logic           mux_busy;

    assign raddr = i_Read_Addr[p*RAW +: RAW];

    regfile_bypass_mux #(
      .DATA_WIDTH      (DW),
      .REG_ADDR_WIDTH  (RAW),
      .NUM_WRITE_PORTS (NUM_WRITE_PORTS)
    ) u_mux (
      .read_addr  (raddr),
      .stored_dat (regs_q[raddr]),
      .pending    (pend_q[raddr]),
      .wr_en      (we_eff),
      .wr_addr    (i_Write_Addr),
      .wr_dat     (i_Write_Data),
      .read_dat   (mux_dat),
      .read_busy  (mux_busy)
    );

    assign o_Read_Data[p*DW +: DW] = ready ? mux_dat : '0;
    assign o_Read_Busy[p]          = ready && mux_busy;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset/clear timing, write/read,
// bypass priority, scoreboard reserve/release, async reset mid-operation.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        ready;

  int vecs;
  int errs;

  regfile_scoreboard #(
    .DATA_WIDTH      (32),
    .REG_ADDR_WIDTH  (5),
    .NUM_READ_PORTS  (2),
    .NUM_WRITE_PORTS (2)
  ) dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_Read_Addr    (rd_addr),
    .o_Read_Data    (rd_data),
    .o_Read_Busy    (rd_busy),
    .i_Write_Enable (we),
    .i_Write_Addr   (wa),
    .i_Write_Data   (wd),
    .i_Reserve_En   (rsv_en),
    .i_Reserve_Addr (rsv_addr),
    .o_Ready        (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we       = 2'b00;
    wa       = '0;
    wd       = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  // Reset, then count edges until o_Ready; then every register reads zero.
  task automatic test_reset();
    idle_inputs();
    rd_addr = '0;
    rst     = 1'b1;
    #2;
    vecs++;
    if (ready !== 1'b0 || rd_busy !== 2'b00 || rd_data !== 64'h0) begin
      $display("FAIL reset_state ready=%b busy=%b data=%h want 0/00/0", ready, rd_busy, rd_data);
      errs++;
    end
    step();
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step();
      vecs++;
      if (ready !== (e == 32)) begin
        $display("FAIL ready_edge%0d got %b want %b", e, ready, (e == 32));
        errs++;
      end
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {a[4:0], 5'(31 - a)};
      #1;
      vecs++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
        $display("FAIL cleared_r%0d data=%h busy=%b want 0/00", a, rd_data, rd_busy);
        errs++;
      end
    end
  endtask

  task automatic test_write_read();
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF};
    rd_addr = {5'd5, 5'd5};
    #1;
    vecs++;
    if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      $display("FAIL wr_r5_bypass got %h want deadbeefdeadbeef", rd_data);
      errs++;
    end
    step();
    idle_inputs();
    #1;
    vecs++;
    if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      $display("FAIL wr_r5_stored got %h want deadbeefdeadbeef", rd_data);
      errs++;
    end
    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'h1234};
    rd_addr = {5'd0, 5'd0};
    #1;
    vecs++;
    if (rd_data !== 64'h0) begin
      $display("FAIL wr_r0_bypass got %h want 0", rd_data);
      errs++;
    end
    step();
    idle_inputs();
    #1;
    vecs++;
    if (rd_data !== 64'h0) begin
      $display("FAIL wr_r0_stored got %h want 0", rd_data);
      errs++;
    end
  endtask

  task automatic test_write_priority();
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
    rd_addr = {5'd7, 5'd7};
    #1;
    vecs++;
    if (rd_data !== {32'h22, 32'h22}) begin
      $display("FAIL prio_bypass got %h want 0000002200000022", rd_data);
      errs++;
    end
    step();
    idle_inputs();
    #1;
    vecs++;
    if (rd_data !== {32'h22, 32'h22}) begin
      $display("FAIL prio_stored got %h want 0000002200000022", rd_data);
      errs++;
    end
  endtask

  task automatic test_reserve();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    rd_addr = {5'd9, 5'd9};
    #1;
    vecs++;
    if (rd_busy !== 2'b00) begin
      $display("FAIL rsv_same_cycle busy=%b want 00", rd_busy);
      errs++;
    end
    step();
    idle_inputs();
    #1;
    vecs++;
    if (rd_busy !== 2'b11) begin
      $display("FAIL rsv_busy busy=%b want 11", rd_busy);
      errs++;
    end
    // Write on port 1 releases r9 and forwards the data in the same cycle.
    we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'h55, 32'h0};
    #1;
    vecs++;
    if (rd_busy !== 2'b00 || rd_data !== {32'h55, 32'h55}) begin
      $display("FAIL wb_bypass busy=%b data=%h want 00/0000005500000055", rd_busy, rd_data);
      errs++;
    end
    step();
    idle_inputs();
    #1;
    vecs++;
    if (rd_busy !== 2'b00 || rd_data !== {32'h55, 32'h55}) begin
      $display("FAIL wb_stored busy=%b data=%h want 00/0000005500000055", rd_busy, rd_data);
      errs++;
    end
    rsv_en = 1'b1; rsv_addr = 5'd9;
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h55};
    step();
    idle_inputs();
    #1;
    vecs++;
    if (rd_busy !== 2'b11 || rd_data !== {32'h55, 32'h55}) begin
      $display("FAIL rsv_and_wr busy=%b data=%h want 11/0000005500000055", rd_busy, rd_data);
      errs++;
    end
    rsv_en = 1'b1; rsv_addr = 5'd9;
    step();
    idle_inputs();
    #1;
    vecs++;
    if (rd_busy !== 2'b11) begin
      $display("FAIL rsv_twice busy=%b want 11", rd_busy);
      errs++;
    end
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr = {5'd9, 5'd0};
    step();
    idle_inputs();
    #1;
    vecs++;
    if (rd_busy !== 2'b10) begin
      $display("FAIL rsv_r0 busy=%b want 10", rd_busy);
      errs++;
    end
  endtask

  // Reserve r4, then reset asynchronously between edges.
  task automatic test_reset_mid_ready();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    step();
    idle_inputs();
    rd_addr = {5'd4, 5'd4};
    #1;
    vecs++;
    if (rd_busy !== 2'b11 || ready !== 1'b1) begin
      $display("FAIL pre_reset busy=%b ready=%b want 11/1", rd_busy, ready);
      errs++;
    end
    #1;
    rst = 1'b1;
    #1;
    vecs++;
    if (ready !== 1'b0 || rd_busy !== 2'b00) begin
      $display("FAIL async_reset ready=%b busy=%b want 0/00", ready, rd_busy);
      errs++;
    end
    step();
    rst = 1'b0;
  endtask

  // Clear restarts; a write and a reserve during CLEAR have no effect.
  task automatic test_clear_ignores();
    rd_addr = {5'd4, 5'd3};
    for (int e = 1; e <= 32; e++) begin
      if (e == 10) begin
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'hAA};
        rsv_en = 1'b1; rsv_addr = 5'd3;
        #1;
        vecs++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
          $display("FAIL clear_wr_visible data=%h busy=%b want 0/00", rd_data, rd_busy);
          errs++;
        end
      end
      step();
      idle_inputs();
      vecs++;
      if (ready !== (e == 32)) begin
        $display("FAIL reclear_edge%0d got %b want %b", e, ready, (e == 32));
        errs++;
      end
    end
    #1;
    vecs++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
      $display("FAIL after_clear r3/r4 data=%h busy=%b want 0/00", rd_data, rd_busy);
      errs++;
    end
    rd_addr = {5'd7, 5'd5};
    #1;
    vecs++;
    if (rd_data !== 64'h0) begin
      $display("FAIL after_clear r5/r7 data=%h want 0", rd_data);
      errs++;
    end
  endtask

  initial begin
    vecs    = 0;
    errs    = 0;
    rst     = 1'b0;
    rd_addr = '0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_write_priority();
    test_reserve();
    test_reset_mid_ready();
    test_clear_ignores();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
